// File: rtl/light_conflict_monitor_if.sv
// Controller light vectors and fault clear in, registered lamp drive and monitor status out.
// master = controller/bench side, slave = light_conflict_monitor.
interface light_conflict_monitor_if;
  logic [2:0] in_M1, in_M2, in_MT, in_S;
  logic       fault_clr;
  logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
  logic       mon_ok;
  logic       fault;
  logic [3:0] fault_code;

  modport master (
    output in_M1, in_M2, in_MT, in_S, fault_clr,
    input  lamp_M1, lamp_M2, lamp_MT, lamp_S, mon_ok, fault, fault_code
  );

  modport slave (
    input  in_M1, in_M2, in_MT, in_S, fault_clr,
    output lamp_M1, lamp_M2, lamp_MT, lamp_S, mon_ok, fault, fault_code
  );
endinterface

// File: rtl/light_conflict_monitor.sv
// Lamp safety stage: 1-cycle registered pass-through, latches a fault code and flashes red on any violation.
// No backpressure; CONFLICT_MON_STALL_EN adds the unchanged-input stall watchdog (fault_code bit 3).
module light_conflict_monitor #(
  parameter int INIT_CYC   = 4,
  parameter int YEL_MIN    = 3,
  parameter int FLASH_HALF = 2
`ifdef CONFLICT_MON_STALL_EN
  ,
  parameter int STALL_MAX  = 15
`endif
) (
  input logic                     clk,
  input logic                     rst,
  light_conflict_monitor_if.slave bus
);
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [3:0][2:0] ALL_RED = {4{RED}};

  localparam int IW = $clog2(INIT_CYC + 1);
  localparam int YW = $clog2(YEL_MIN + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYC - 1);
  localparam logic [YW-1:0] YEL_SAT    = YW'(YEL_MIN);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FAULT} state_t;
  state_t state, state_nxt;

  // Approach index: 0 = M1, 1 = M2, 2 = MT, 3 = S.
  logic [3:0][2:0]    cur, prev, lamp, lamp_nxt;
  logic [3:0][YW-1:0] ycnt;
  logic [IW-1:0]      init_cnt, init_nxt;
  logic [FW-1:0]      flash_cnt, flash_nxt;
  logic               flash_dark, dark_nxt;
  logic [3:0]         code, code_nxt, viol;

  assign cur = {bus.in_S, bus.in_MT, bus.in_M2, bus.in_M1};

`ifdef CONFLICT_MON_STALL_EN
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX);
  logic [SW-1:0] stall_cnt;

  // Saturates at STALL_MAX; one more unchanged sample beyond that is the fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (state != ST_RUN || cur != prev)
      stall_cnt <= '0;
    else if (stall_cnt != STALL_LAST)
      stall_cnt <= stall_cnt + SW'(1);
  end
`endif

  always_comb begin
    viol = '0;
    for (int i = 0; i < 4; i++) begin
      if (cur[i] != RED && cur[i] != YEL && cur[i] != GRN)
        viol[0] = 1'b1;
      if ((prev[i] == GRN && cur[i] == RED) ||
          (prev[i] == RED && cur[i] == YEL) ||
          (prev[i] == YEL && cur[i] == GRN) ||
          (prev[i] == YEL && cur[i] == RED && ycnt[i] < YEL_SAT))
        viol[2] = 1'b1;
    end
    viol[1] = (cur[3] != RED && (cur[0] != RED || cur[1] != RED || cur[2] != RED)) ||
              (cur[2] != RED && cur[1] != RED);
`ifdef CONFLICT_MON_STALL_EN
    viol[3] = (cur == prev) && (stall_cnt == STALL_LAST);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lamp_nxt  = lamp;
    init_nxt  = init_cnt;
    code_nxt  = code;
    flash_nxt = flash_cnt;
    dark_nxt  = flash_dark;
    unique case (state)
      ST_INIT: begin
        lamp_nxt = ALL_RED;
        if (init_cnt == INIT_LAST) begin
          state_nxt = ST_RUN;
          init_nxt  = '0;
        end else begin
          init_nxt = init_cnt + IW'(1);
        end
      end
      ST_RUN: begin
        if (|viol) begin
          state_nxt = ST_FAULT;
          lamp_nxt  = ALL_RED;
          code_nxt  = viol;
          flash_nxt = '0;
          dark_nxt  = 1'b0;
        end else begin
          lamp_nxt = cur;
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr) begin
          state_nxt = ST_INIT;
          lamp_nxt  = ALL_RED;
          code_nxt  = '0;
          init_nxt  = '0;
        end else if (flash_cnt == FLASH_LAST) begin
          flash_nxt = '0;
          dark_nxt  = ~flash_dark;
          lamp_nxt  = flash_dark ? ALL_RED : '0;
        end else begin
          flash_nxt = flash_cnt + FW'(1);
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp       <= ALL_RED;
      init_cnt   <= '0;
      code       <= '0;
      flash_cnt  <= '0;
      flash_dark <= 1'b0;
    end else begin
      lamp       <= lamp_nxt;
      init_cnt   <= init_nxt;
      code       <= code_nxt;
      flash_cnt  <= flash_nxt;
      flash_dark <= dark_nxt;
    end
  end

  // History tracks the inputs in every state so RUN starts with a valid previous sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= ALL_RED;
      ycnt <= '0;
    end else begin
      prev <= cur;
      for (int i = 0; i < 4; i++) begin
        if (cur[i] != YEL)
          ycnt[i] <= '0;
        else if (ycnt[i] != YEL_SAT)
          ycnt[i] <= ycnt[i] + YW'(1);
      end
    end
  end

  assign bus.lamp_M1    = lamp[0];
  assign bus.lamp_M2    = lamp[1];
  assign bus.lamp_MT    = lamp[2];
  assign bus.lamp_S     = lamp[3];
  assign bus.mon_ok     = (state == ST_RUN);
  assign bus.fault      = (state == ST_FAULT);
  assign bus.fault_code = code;
endmodule

// File: tb/tb_light_conflict_monitor.sv
// Bench for light_conflict_monitor: directed scenarios plus random traffic against a rule-level model.
module tb_light_conflict_monitor;
  localparam int INIT_CYC   = 4;
  localparam int YEL_MIN    = 3;
  localparam int FLASH_HALF = 2;
  localparam int STALL_MAX  = 15;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  light_conflict_monitor_if bus();
  light_conflict_monitor dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Model: 0 = INIT, 1 = RUN, 2 = FAULT; m_age = edges since entering the state.
  int         m_state;
  int         m_age;
  int         m_same;
  int         m_yrun [4];
  logic [2:0] m_prev [4];
  logic [2:0] m_lamp [4];
  logic [3:0] m_code;

  function automatic bit legal(input logic [2:0] v);
    return v == R || v == Y || v == G;
  endfunction

  function automatic bit trans_ok(input logic [2:0] a, input logic [2:0] b);
    return a == b || (a == R && b == G) || (a == G && b == Y) || (a == Y && b == R);
  endfunction

  function void model_reset();
    m_state = 0; m_age = 0; m_same = 0; m_code = 4'b0;
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = R; m_yrun[i] = 0; m_lamp[i] = R;
    end
  endfunction

  function void model_step(input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] t, input logic [2:0] s, input logic clr);
    logic [2:0] c [4];
    logic [3:0] v;
    bit         same;
    c[0] = a; c[1] = b; c[2] = t; c[3] = s;
    v = 4'b0;
    same = 1'b1;
    for (int i = 0; i < 4; i++) if (c[i] != m_prev[i]) same = 1'b0;
    if (m_state == 0) begin
      m_age++;
      for (int i = 0; i < 4; i++) m_lamp[i] = R;
      if (m_age == INIT_CYC) begin m_state = 1; m_age = 0; m_same = 0; end
    end else if (m_state == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (!legal(c[i])) v[0] = 1'b1;
        else if (legal(m_prev[i]) && !trans_ok(m_prev[i], c[i])) v[2] = 1'b1;
        if (m_prev[i] == Y && c[i] == R && m_yrun[i] < YEL_MIN) v[2] = 1'b1;
      end
      if (c[3] != R && (c[0] != R || c[1] != R || c[2] != R)) v[1] = 1'b1;
      if (c[2] != R && c[1] != R) v[1] = 1'b1;
`ifdef CONFLICT_MON_STALL_EN
      m_same = same ? m_same + 1 : 0;
      if (m_same > STALL_MAX) v[3] = 1'b1;
`endif
      if (v != 4'b0) begin
        m_state = 2; m_age = 0; m_code = v;
        for (int i = 0; i < 4; i++) m_lamp[i] = R;
      end else begin
        for (int i = 0; i < 4; i++) m_lamp[i] = c[i];
      end
    end else begin
      if (clr) begin
        m_state = 0; m_age = 0; m_code = 4'b0;
        for (int i = 0; i < 4; i++) m_lamp[i] = R;
      end else begin
        m_age++;
        for (int i = 0; i < 4; i++) m_lamp[i] = ((m_age / FLASH_HALF) % 2 == 1) ? 3'b000 : R;
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_yrun[i] = (c[i] == Y) ? m_yrun[i] + 1 : 0;
      m_prev[i] = c[i];
    end
  endfunction

  function automatic logic [17:0] exp_vec();
    return {m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3], m_state == 1, m_state == 2, m_code};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {bus.lamp_M1, bus.lamp_M2, bus.lamp_MT, bus.lamp_S, bus.mon_ok, bus.fault, bus.fault_code};
  endfunction

  task automatic tick(input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] t, input logic [2:0] s, input logic clr);
    bus.in_M1 = a; bus.in_M2 = b; bus.in_MT = t; bus.in_S = s; bus.fault_clr = clr;
    @(posedge clk);
    model_step(a, b, t, s, clr);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_M1 = G; bus.in_M2 = G; bus.in_MT = R; bus.in_S = R; bus.fault_clr = 1'b0;
    model_reset();
    #12;
    checks++;
    if (dut_vec() !== {12'b100_100_100_100, 1'b0, 1'b0, 4'b0000}) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), {12'b100_100_100_100, 6'b0});
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < INIT_CYC; k++) begin
      tick(G, G, R, R, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL reset_init k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.mon_ok !== 1'b1) begin
      failures++; $display("FAIL init_done mon_ok got=%b exp=1", bus.mon_ok);
    end
  endtask

  task automatic test_legal_sequence();
    logic [2:0] seg [7][4];
    int         len [7];
    seg[0] = '{G, G, R, R}; len[0] = 8;
    seg[1] = '{G, Y, R, R}; len[1] = 3;
    seg[2] = '{G, R, G, R}; len[2] = 6;
    seg[3] = '{Y, R, Y, R}; len[3] = 4;
    seg[4] = '{R, R, R, G}; len[4] = 4;
    seg[5] = '{R, R, R, Y}; len[5] = 3;
    seg[6] = '{R, R, R, R}; len[6] = 2;
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < len[p]; k++) begin
        tick(seg[p][0], seg[p][1], seg[p][2], seg[p][3], 1'b0);
        checks++;
        if (dut_vec() !== exp_vec() || bus.fault !== 1'b0 ||
            {bus.lamp_M1, bus.lamp_M2, bus.lamp_MT, bus.lamp_S} !==
            {seg[p][0], seg[p][1], seg[p][2], seg[p][3]}) begin
          failures++; $display("FAIL legal_seq p=%0d k=%0d got=%h exp=%h", p, k, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_conflict();
    tick(G, G, R, R, 1'b0);
    tick(G, G, R, G, 1'b0);
    checks++;
    if (bus.fault !== 1'b1 || bus.fault_code !== 4'b0010 || bus.mon_ok !== 1'b0 ||
        {bus.lamp_M1, bus.lamp_M2, bus.lamp_MT, bus.lamp_S} !== 12'b100_100_100_100) begin
      failures++; $display("FAIL conflict_entry got=%h exp=%h", dut_vec(), {12'b100_100_100_100, 2'b01, 4'b0010});
    end
    for (int k = 1; k <= 6; k++) begin
      tick(G, G, R, G, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL flash k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (k == 2) begin
        checks++;
        if (bus.lamp_S !== 3'b000) begin
          failures++; $display("FAIL flash_dark lamp_S got=%b exp=000", bus.lamp_S);
        end
      end
    end
  endtask

  task automatic test_clear();
    tick(G, G, R, R, 1'b1);
    checks++;
    if (dut_vec() !== exp_vec() || bus.fault !== 1'b0) begin
      failures++; $display("FAIL clear_edge got=%h exp=%h", dut_vec(), exp_vec());
    end
    for (int k = 0; k < INIT_CYC; k++) begin
      tick(G, G, R, R, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL clear_init k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_short_yellow();
    tick(G, Y, R, R, 1'b0);
    tick(G, Y, R, R, 1'b0);
    tick(G, R, R, R, 1'b0);
    checks++;
    if (bus.fault_code !== 4'b0100 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL short_yellow code got=%b exp=0100", bus.fault_code);
    end
  endtask

  task automatic test_enc_conflict();
    tick(G, G, 3'b011, R, 1'b0);
    checks++;
    if (bus.fault_code !== 4'b0011 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL enc_conflict code got=%b exp=0011", bus.fault_code);
    end
  endtask

  task automatic test_stall();
    logic [3:0] want;
`ifdef CONFLICT_MON_STALL_EN
    want = 4'b1000;
`else
    want = 4'b0000;
`endif
    for (int k = 0; k < 20; k++) begin
      tick(G, G, R, R, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL stall k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.fault_code !== want) begin
      failures++; $display("FAIL stall_code got=%b exp=%b", bus.fault_code, want);
    end
    if (m_state == 2) test_clear();
  endtask

  task automatic test_random();
    logic [2:0] rv [4];
    logic [2:0] col [3];
    logic       clr;
    int         r;
    col[0] = R; col[1] = Y; col[2] = G;
    for (int i = 0; i < 4; i++) rv[i] = R;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 99);
        if (r < 8) rv[i] = col[$urandom_range(0, 2)];
        else if (r < 9) rv[i] = 3'($urandom_range(0, 7));
      end
      clr = (m_state == 2) && ($urandom_range(0, 3) == 0);
      tick(rv[0], rv[1], rv[2], rv[3], clr);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget = 20;
    while (m_state != 2 && budget > 0) begin
      tick(G, G, R, G, 1'b0);
      budget--;
    end
    checks++;
    if (bus.fault !== 1'b1 || m_state != 2) begin
      failures++; $display("FAIL reach_fault got=%b exp=1", bus.fault);
    end
    for (int k = 0; k < 3; k++) tick(G, G, R, G, 1'b0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== {12'b100_100_100_100, 6'b0}) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), {12'b100_100_100_100, 6'b0});
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < INIT_CYC; k++) begin
      tick(G, G, R, R, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL reinit k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.mon_ok !== 1'b1) begin
      failures++; $display("FAIL reinit_done mon_ok got=%b exp=1", bus.mon_ok);
    end
  endtask

  initial begin
    test_reset();
    test_legal_sequence();
    test_conflict();
    test_clear();
    test_short_yellow();
    test_clear();
    test_enc_conflict();
    test_clear();
    test_stall();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
